// File: rtl/mul8_tree_scheduler.sv
// mul8_tree_scheduler
//   Shares one external, non-stallable, pipelined 8x8 multiplier tree between N
//   requesters. A round-robin arbiter accepts at most one operand pair per cycle,
//   registers it onto tree_a/tree_b and tracks its requester tag through a
//   STAGES-deep valid/tag shift register that mirrors the tree latency. When the
//   tag emerges, tree_prod is captured with it into a DEPTH-entry result FIFO.
//   Issue is credit-gated: in-flight operations plus queued results never exceed
//   DEPTH, so the FIFO cannot overflow even though the tree cannot be stalled.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/a/b       per-requester operand pairs, lane i at bits [8i+7:8i]
//   req_ready           one-hot grant, combinational
//   tree_a/b, tree_valid  registered operands driven to the external tree
//   tree_prod           tree product, valid STAGES cycles after tree_a/b
//   res_valid/ready     result FIFO handshake (pop on valid & ready)
//   res_prod, res_tag   head-of-FIFO product and requester index
//   busy                anything in flight or queued

module mul8_tree_scheduler #(
   parameter int N      = 4,
   parameter int STAGES = 7,
   parameter int DEPTH  = 8,
   parameter int TW     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   input  logic [8*N-1:0]   req_a,
   input  logic [8*N-1:0]   req_b,
   output logic [N-1:0]     req_ready,
   output logic [7:0]       tree_a,
   output logic [7:0]       tree_b,
   output logic             tree_valid,
   input  logic [15:0]      tree_prod,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      res_prod,
   output logic [TW-1:0]    res_tag,
   output logic             busy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [TW-1:0] LAST_REQ = TW'(N - 1);

   typedef struct packed {
      logic [15:0]   prod;
      logic [TW-1:0] tag;
   } entry_t;

   // Arbitration / issue state
   logic [TW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [7:0]        tree_a_q, tree_b_q;
   logic [TW-1:0]     tree_tag_q;
   logic              tree_valid_q;

   // Tag pipeline shadowing the tree latency
   logic [STAGES-1:0] sr_valid_q;
   logic [TW-1:0]     sr_tag_q [STAGES];

   // Credit counters and result FIFO
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [CW-1:0]     occ_q, occ_d;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   entry_t            mem [DEPTH];

   logic [7:0]        a_lane [N];
   logic [7:0]        b_lane [N];
   logic [TW-1:0]     grant_idx;
   logic              can_issue;
   logic              transfer;
   logic              capture;
   logic              pop;
   entry_t            head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Credits use registered counts only, so a pop frees its slot one cycle later.
   assign can_issue = ({1'b0, inflight_q} + {1'b0, occ_q}) < DEPTH_C;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_lane[i] = req_a[8*i +: 8];
         b_lane[i] = req_b[8*i +: 8];
      end
   end

   // Round-robin search starting at rr_ptr; nothing is granted during reset.
   always_comb begin
      logic          found;
      logic [TW-1:0] cand;
      // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
      req_ready = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = TW'((int'(rr_ptr_q) + k) % N);
         if (can_issue && !rst && !found && req_valid[cand]) begin
            found            = 1'b1;
            req_ready[cand]  = 1'b1;
            grant_idx        = cand;
         end
      end
   end

   assign transfer = |(req_valid & req_ready);
   assign capture  = sr_valid_q[STAGES-1];
   assign pop      = res_valid & res_ready;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (transfer) begin
         rr_ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + TW'(1);
      end
      inflight_d = inflight_q + CW'(transfer) - CW'(capture);
      occ_d      = occ_q + CW'(capture) - CW'(pop);
   end

   // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         tree_a_q     <= '0;
         tree_b_q     <= '0;
         tree_tag_q   <= '0;
         tree_valid_q <= 1'b0;
         sr_valid_q   <= '0;
         for (int k = 0; k < STAGES; k++) sr_tag_q[k] <= '0;
         inflight_q   <= '0;
         occ_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         tree_valid_q <= transfer;
         if (transfer) begin
            tree_a_q   <= a_lane[grant_idx];
            tree_b_q   <= b_lane[grant_idx];
            tree_tag_q <= grant_idx;
         end
         sr_valid_q[0] <= tree_valid_q;
         sr_tag_q[0]   <= tree_tag_q;
         for (int k = 1; k < STAGES; k++) begin
            sr_valid_q[k] <= sr_valid_q[k-1];
            sr_tag_q[k]   <= sr_tag_q[k-1];
         end
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         if (capture) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   // NOTE: the storage array is not reset; an entry is only read once the occupancy count marks it valid.
   always_ff @(posedge clk) begin
      if (capture) mem[wr_ptr_q] <= '{prod: tree_prod, tag: sr_tag_q[STAGES-1]};
   end

   assign head       = mem[rd_ptr_q];
   assign res_valid  = (occ_q != '0);
   // Gate the head so an empty FIFO presents zeros instead of stale or uninitialised data.
   assign res_prod   = res_valid ? head.prod : '0;
   assign res_tag    = res_valid ? head.tag  : '0;
   assign tree_a     = tree_a_q;
   assign tree_b     = tree_b_q;
   assign tree_valid = tree_valid_q;
   assign busy       = (inflight_q != '0) || (occ_q != '0);

endmodule

// File: tb/tb_mul8_tree_scheduler.sv
// tb_mul8_tree_scheduler
//   Drives mul8_tree_scheduler (default parameters) plus a second copy with
//   DEPTH=4. Each copy gets a bench-side 7-stage multiplier pipeline standing in
//   for the external tree. Directed table vectors check arbitration, latency and
//   products; hand sequences cover full-rate issue, backpressure, random traffic
//   and reset with work in flight.

module tb_mul8_tree_scheduler;

   localparam int N      = 4;
   localparam int STAGES = 7;
   localparam int TW     = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [N-1:0]      req_valid, req_ready;
   logic [8*N-1:0]    req_a, req_b;
   logic [7:0]        tree_a, tree_b;
   logic              tree_valid;
   logic [15:0]       tree_prod;
   logic              res_valid, res_ready;
   logic [15:0]       res_prod;
   logic [TW-1:0]     res_tag;
   logic              busy;

   logic [N-1:0]      req_valid4, req_ready4;
   logic [8*N-1:0]    req_a4, req_b4;
   logic [7:0]        tree_a4, tree_b4;
   logic              tree_valid4;
   logic [15:0]       tree_prod4;
   logic              res_valid4, res_ready4;
   logic [15:0]       res_prod4;
   logic [TW-1:0]     res_tag4;
   logic              busy4;

   mul8_tree_scheduler #(.N(N), .STAGES(STAGES), .DEPTH(8), .TW(TW)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .tree_a(tree_a), .tree_b(tree_b), .tree_valid(tree_valid),
      .tree_prod(tree_prod), .res_valid(res_valid), .res_ready(res_ready),
      .res_prod(res_prod), .res_tag(res_tag), .busy(busy));

   mul8_tree_scheduler #(.N(N), .STAGES(STAGES), .DEPTH(4), .TW(TW)) u_dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid4), .req_a(req_a4), .req_b(req_b4),
      .req_ready(req_ready4), .tree_a(tree_a4), .tree_b(tree_b4), .tree_valid(tree_valid4),
      .tree_prod(tree_prod4), .res_valid(res_valid4), .res_ready(res_ready4),
      .res_prod(res_prod4), .res_tag(res_tag4), .busy(busy4));

   // External tree stand-ins: product appears STAGES cycles after the operands.
   logic [15:0] pipe  [STAGES];
   logic [15:0] pipe4 [STAGES];
   always @(posedge clk) begin
      pipe[0]  <= {8'h00, tree_a}  * {8'h00, tree_b};
      pipe4[0] <= {8'h00, tree_a4} * {8'h00, tree_b4};
      for (int k = 1; k < STAGES; k++) begin
         pipe[k]  <= pipe[k-1];
         pipe4[k] <= pipe4[k-1];
      end
   end
   assign tree_prod  = pipe[STAGES-1];
   assign tree_prod4 = pipe4[STAGES-1];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Requester lane data and a result scoreboard in issue order.
   logic [7:0] la [N];
   logic [7:0] lb [N];
   logic [N-1:0] acc;

   typedef struct packed {
      logic [15:0]   prod;
      logic [TW-1:0] tag;
   } exp_t;
   exp_t sb[$];
   int n_xfer = 0;
   int n_pop  = 0;

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_a[8*i +: 8] = la[i];
         req_b[8*i +: 8] = lb[i];
      end
   endtask

   // Called once per cycle after inputs settle: score pops, record grants.
   task automatic observe();
      exp_t e;
      int   idx;
      acc = req_valid & req_ready;
      if (res_valid && res_ready) begin
         n_pop++;
         check("pop has expected entry", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result prod", res_prod, e.prod);
            check("result tag",  res_tag,  e.tag);
         end
      end
      if (acc != '0) begin
         check("grant onehot", $countones(acc), 1);
         idx = 0;
         for (int i = N - 1; i >= 0; i--) if (acc[i]) idx = i;
         e.prod = {8'h00, la[idx]} * {8'h00, lb[idx]};
         e.tag  = TW'(idx);
         sb.push_back(e);
         n_xfer++;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 40; k++) begin
         #1;
         observe();
         if (sb.size() == 0 && !busy) break;
         step();
      end
      check("drain scoreboard empty", sb.size(), 0);
      check("drain busy", busy, 0);
   endtask

   typedef struct {
      logic [N-1:0]  mask;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [TW-1:0] tag;
      logic [15:0]   prod;
   } vec_t;
   vec_t vt [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, g, g4, p4, x0, p0, t, stale;
      logic [N-1:0] exp_rdy;

      // Expected grants follow rr_ptr=3 left by the single-request test.
      vt[0] = '{4'b1111, 32'h12776655, 32'h34443322, 2'd3, 16'h03A8};
      vt[1] = '{4'b0110, 32'h99880066, 32'h1122AB33, 2'd1, 16'h0000};
      vt[2] = '{4'b0011, 32'h09080780, 32'h05040302, 2'd0, 16'h0100};
      vt[3] = '{4'b1001, 32'hFF020304, 32'h01050607, 2'd3, 16'h00FF};
      vt[4] = '{4'b0001, 32'h1020300F, 32'h4050600F, 2'd0, 16'h00E1};
      vt[5] = '{4'b1111, 32'h0102A503, 32'h04055A06, 2'd1, 16'h3A02};
      vt[6] = '{4'b0101, 32'h33C82211, 32'h77646655, 2'd2, 16'h4E20};
      vt[7] = '{4'b0101, 32'h0A0B0CFE, 32'h0D0E0FFF, 2'd0, 16'hFD02};

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
      req_valid4 = '1; req_a4 = 32'hD17E2B9F; req_b4 = 32'h3C55E008; res_ready4 = 1'b1;
      step(); step();

      // Reset state, with requests pending
      req_valid = '1;
      #1;
      check("reset req_ready",  req_ready, 0);
      check("reset tree_valid", tree_valid, 0);
      check("reset tree_a",     tree_a, 0);
      check("reset tree_b",     tree_b, 0);
      check("reset res_valid",  res_valid, 0);
      check("reset res_prod",   res_prod, 0);
      check("reset res_tag",    res_tag, 0);
      check("reset busy",       busy, 0);
      check("reset req_ready4", req_ready4, 0);
      check("reset tree_valid4", tree_valid4, 0);
      check("reset busy4",      busy4, 0);
      step();
      rst = 1'b0; req_valid = '0;

      // Single request from requester 2 in cycle 0
      req_a = 32'h00FF0000; req_b = 32'h00FF0000; req_valid = 4'b0100;
      #1;
      check("t1 grant", req_ready, 4'b0100);
      step(); req_valid = '0; #1;
      check("t1 tree_valid", tree_valid, 1);
      check("t1 tree_a", tree_a, 8'hFF);
      check("t1 tree_b", tree_b, 8'hFF);
      for (int c = 2; c <= 8; c++) step();
      #1;
      check("t1 res_valid cycle 8", res_valid, 0);
      step(); #1;
      check("t1 res_valid cycle 9", res_valid, 1);
      check("t1 res_prod", res_prod, 16'hFE01);
      check("t1 res_tag",  res_tag, 2);
      check("t1 busy at pop", busy, 1);
      step(); #1;
      check("t1 busy after pop", busy, 0);
      check("t1 res_valid after pop", res_valid, 0);

      // Table of single transactions: grant choice, latency, product, tag
      for (int r = 0; r < 8; r++) begin
         step();
         req_a = vt[r].a; req_b = vt[r].b; req_valid = vt[r].mask;
         #1;
         check($sformatf("vec%0d grant", r), req_ready, 4'b0001 << vt[r].tag);
         step(); req_valid = '0; #1;
         n = 0;
         while (!res_valid && n < 20) begin
            step(); #1; n++;
         end
         check($sformatf("vec%0d latency", r), n, 8);
         check($sformatf("vec%0d prod", r), res_prod, vt[r].prod);
         check($sformatf("vec%0d tag", r), res_tag, vt[r].tag);
      end

      // All requesters valid, consumer always ready; credits recycle every 10 cycles
      step(); rst = 1'b1; step(); step(); rst = 1'b0;
      sb.delete();
      la = '{8'h13, 8'h27, 8'h9C, 8'hF0};
      lb = '{8'h45, 8'hE1, 8'h0A, 8'h7F};
      drive(); req_valid = '1; res_ready = 1'b1;
      g = 0; g4 = 0; p4 = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         exp_rdy = ((c % 10) < 8) ? 4'(4'b0001 << (g % 4)) : 4'b0000;
         check($sformatf("t2 grant c%0d", c), req_ready, exp_rdy);
         if (exp_rdy != '0) g++;
         exp_rdy = ((c % 10) < 4) ? 4'(4'b0001 << (g4 % 4)) : 4'b0000;
         check($sformatf("t4 grant c%0d", c), req_ready4, exp_rdy);
         if (exp_rdy != '0) g4++;
         if (res_valid4) begin
            t = p4 % 4;
            check("t4 tag", res_tag4, t);
            check("t4 prod", res_prod4, {8'h00, req_a4[8*t +: 8]} * {8'h00, req_b4[8*t +: 8]});
            p4++;
         end
         observe();
         step();
      end
      req_valid = '0;
      drain();

      // Consumer stalled: exactly DEPTH transfers, then release
      step();
      la = '{8'h81, 8'h02, 8'h7F, 8'hC3};
      lb = '{8'h03, 8'hFE, 8'h80, 8'h11};
      drive(); req_valid = '1; res_ready = 1'b0;
      x0 = n_xfer;
      for (int c = 0; c < 20; c++) begin
         #1; observe(); step();
      end
      #1;
      check("t3 transfers", n_xfer - x0, 8);
      check("t3 stalled", req_ready, 0);
      check("t3 res_valid held", res_valid, 1);
      step();
      res_ready = 1'b1;
      p0 = n_pop;
      for (int k = 0; k < 30; k++) begin
         #1;
         if (k == 0) check("t3 no credit on pop cycle", req_ready, 0);
         if (k == 1) check("t3 issue resumes", 32'(req_ready != '0), 1);
         observe();
         if (n_pop - p0 >= 8) break;
         step();
      end
      check("t3 pops", n_pop - p0, 8);
      step(); req_valid = '0;
      drain();

      // Random operands, valids and consumer backpressure
      step();
      for (int i = 0; i < N; i++) begin
         la[i] = 8'($urandom); lb[i] = 8'($urandom);
      end
      req_valid = 4'($urandom);
      drive();
      x0 = n_xfer; p0 = n_pop;
      for (int c = 0; c < 300; c++) begin
         #1; observe(); step();
         res_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               la[i] = 8'($urandom);
               lb[i] = 8'($urandom);
            end
         end
         drive();
      end
      req_valid = '0; res_ready = 1'b1;
      drain();
      check("t5 nothing lost", n_pop - p0, n_xfer - x0);
      check("t5 traffic seen", 32'((n_xfer - x0) > 50), 1);

      // Reset with 5 in flight and 2 queued
      step(); rst = 1'b1; step(); step(); rst = 1'b0;
      sb.delete();
      res_ready = 1'b0; req_valid = '1; t = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (|(req_valid & req_ready)) t++;
         step();
         if (t >= 7) req_valid = '0;
      end
      #1;
      check("t6 transfers", t, 7);
      check("t6 res_valid before rst", res_valid, 1);
      check("t6 busy before rst", busy, 1);
      rst = 1'b1;
      step(); #1;
      check("t6 res_valid after rst", res_valid, 0);
      check("t6 busy after rst", busy, 0);
      check("t6 tree_valid after rst", tree_valid, 0);
      rst = 1'b0; res_ready = 1'b1; stale = 0;
      for (int c = 0; c < 30; c++) begin
         step(); #1;
         if (res_valid || busy) stale++;
      end
      check("t6 stale results", stale, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
